// File: rtl/pci_burst_mem.sv
// PCI burst target memory: byte-enabled single-port RAM with an
// auto-incrementing burst address, registered reads and an overrun flag.
module pci_burst_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int WRAP_EN = 0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic [ADDR_W-1:0]   ADDR_M,
  input  logic                Mem_WE,
  input  logic [DATA_W/8-1:0] BE,
  input  logic                VALID,
  input  logic                LAST,
  input  logic [DATA_W-1:0]   IN_DATA_M,
  output logic [DATA_W-1:0]   OUT_DATA_M,
  output logic                OUT_VALID,
  output logic                BUSY,
  output logic                ERR,
  output logic [ADDR_W-1:0]   CUR_ADDR
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] TOP = '1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic              beat;
  logic              wr_beat;
  logic              rd_beat;
  logic [DATA_W-1:0] be_mask;

  assign beat    = (state_q == S_BURST) && VALID;
  assign wr_beat = beat && dir_q;
  assign rd_beat = beat && !dir_q;

  always_comb begin
    be_mask = '0;
    for (int k = 0; k < NB; k++) begin
      be_mask[8*k +: 8] = {8{BE[k]}};
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    dir_d    = dir_q;
    err_d    = err_q;
    rvalid_d = rd_beat;
    rdata_d  = rdata_q;
    if (rd_beat) begin
      rdata_d = mem_q[addr_q] & be_mask;
    end
    unique case (1'b1)
      (state_q == S_BURST): begin
        if (VALID) begin
          // LAST outranks the top-of-memory check
          if (LAST) begin
            state_d = S_IDLE;
          end else if (addr_q != TOP) begin
            addr_d = addr_q + 1'b1;
          end else if (WRAP_EN != 0) begin
            addr_d = '0;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        if (START) begin
          addr_d  = ADDR_M;
          dir_d   = Mem_WE;
          err_d   = 1'b0;
          state_d = S_BURST;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Array contents survive reset on purpose
  always_ff @(posedge CLK) begin
    if (wr_beat) begin
      for (int k = 0; k < NB; k++) begin
        if (BE[k]) begin
          mem_q[addr_q][8*k +: 8] <= IN_DATA_M[8*k +: 8];
        end
      end
    end
  end

  assign OUT_DATA_M = rdata_q;
  assign OUT_VALID  = rvalid_q;
  assign BUSY       = (state_q == S_BURST);
  assign ERR        = err_q;
  assign CUR_ADDR   = addr_q;

endmodule
